// File: rtl/sps_rx_pkg.sv
// Shared defaults and state encoding for the SPS stream receiver.
package sps_rx_pkg;
   localparam int SPS_DATA_W = 64;
   localparam int SPS_DEPTH  = 3072;
   localparam int SPS_ADDR_W = 12;

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_READY = 1'b1
   } sps_state_e;
endpackage

// File: rtl/sps_rx_if.sv
// Stream, read-port and status signals between the SPS/attention side and the receiver.
interface sps_rx_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 12
);
   logic              i_data_valid;
   logic [DATA_W-1:0] i_fmap;
   logic [DATA_W-1:0] i_patchdata;
   logic              i_attn_done;
   logic              i_rd_req;
   logic [ADDR_W-1:0] i_rd_addr;
   logic              o_rd_valid;
   logic [DATA_W-1:0] o_rd_fmap;
   logic [DATA_W-1:0] o_rd_patch;
   logic              o_frame_ready;
   logic [ADDR_W:0]   o_wr_cnt;
   logic              o_overflow;

   modport master (
      output i_data_valid, i_fmap, i_patchdata, i_attn_done, i_rd_req, i_rd_addr,
      input  o_rd_valid, o_rd_fmap, o_rd_patch, o_frame_ready, o_wr_cnt, o_overflow
   );

   modport slave (
      input  i_data_valid, i_fmap, i_patchdata, i_attn_done, i_rd_req, i_rd_addr,
      output o_rd_valid, o_rd_fmap, o_rd_patch, o_frame_ready, o_wr_cnt, o_overflow
   );
endinterface

// File: rtl/sps_rx_dpram.sv
// Simple dual-port frame buffer: synchronous write, registered read, no reset on contents.
module sps_rx_dpram #(
   parameter int W      = 128,
   parameter int DEPTH  = 3072,
   parameter int ADDR_W = 12
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [W-1:0]      wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [W-1:0]      rdata_o
);
   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/sps_stream_receiver.sv
// Captures one SPS frame into the local buffer, then serves random reads until released.
//   state    | meaning
//   ST_FILL  | accepting stream words, reads ignored
//   ST_READY | frame complete, reads served, stream words dropped as overflow
module sps_stream_receiver
   import sps_rx_pkg::*;
#(
   parameter int DATA_W = SPS_DATA_W,
   parameter int DEPTH  = SPS_DEPTH,
   parameter int ADDR_W = SPS_ADDR_W
) (
   input  logic    s_clk,
   input  logic    s_rst_n,
   sps_rx_if.slave bus
);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

   sps_state_e          state_q, state_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                rd_valid_q, rd_oor_q;
   logic [DATA_W-1:0]   hold_fmap_q, hold_patch_q;
   logic                we;
   logic [ADDR_W-1:0]   waddr;
   logic                rd_fire, rd_oor, re;
   logic [2*DATA_W-1:0] rdata, rd_word;

   assign rd_oor  = {1'b0, bus.i_rd_addr} >= DEPTH_C;
   assign rd_fire = bus.i_rd_req && (state_q == ST_READY);
   assign re      = rd_fire && !rd_oor;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      we      = 1'b0;
      waddr   = cnt_q[ADDR_W-1:0];
      case (state_q)
         ST_FILL: begin
            if (bus.i_attn_done) begin
               // abort restarts the frame; a coincident word becomes word 0
               waddr = '0;
               we    = bus.i_data_valid;
               cnt_d = (ADDR_W+1)'(bus.i_data_valid);
            end else if (bus.i_data_valid) begin
               we    = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_C) state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (bus.i_data_valid) ovf_d = 1'b1;
            if (bus.i_attn_done) begin
               state_d = ST_FILL;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q <= ST_FILL;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   sps_rx_dpram #(
      .W      (2*DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (s_clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i ({bus.i_fmap, bus.i_patchdata}),
      .re_i    (re),
      .raddr_i (bus.i_rd_addr),
      .rdata_o (rdata)
   );

   // RAM output feeds the port during the valid cycle; the hold registers keep it afterwards
   assign rd_word = rd_oor_q ? '0 : rdata;

   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         rd_valid_q   <= 1'b0;
         rd_oor_q     <= 1'b0;
         hold_fmap_q  <= '0;
         hold_patch_q <= '0;
      end else begin
         rd_valid_q <= rd_fire;
         rd_oor_q   <= rd_oor;
         if (rd_valid_q) begin
            hold_fmap_q  <= rd_word[2*DATA_W-1:DATA_W];
            hold_patch_q <= rd_word[DATA_W-1:0];
         end
      end
   end

   assign bus.o_rd_valid    = rd_valid_q;
   assign bus.o_rd_fmap     = rd_valid_q ? rd_word[2*DATA_W-1:DATA_W] : hold_fmap_q;
   assign bus.o_rd_patch    = rd_valid_q ? rd_word[DATA_W-1:0] : hold_patch_q;
   assign bus.o_frame_ready = (state_q == ST_READY);
   assign bus.o_wr_cnt      = cnt_q;
   assign bus.o_overflow    = ovf_q;
endmodule

// File: tb/tb_sps_stream_receiver.sv
// Directed bench for the SPS stream receiver: fill, overflow, release, abort, edge reads, async reset.
`timescale 1ns/1ps
module tb_sps_stream_receiver;
   logic s_clk;
   logic s_rst_n;
   int   total;
   int   bad;

   sps_rx_if #(.DATA_W(64), .ADDR_W(12)) bus ();

   sps_stream_receiver #(.DATA_W(64), .DEPTH(3072), .ADDR_W(12)) dut (
      .s_clk   (s_clk),
      .s_rst_n (s_rst_n),
      .bus     (bus)
   );

   initial s_clk = 1'b0;
   always #5 s_clk = ~s_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [63:0] fm(input int frame, input int i);
      case (frame)
         1:       fm = 64'(i);
         2:       fm = 64'hDEAD_0000_0000_0000 | 64'(i);
         3:       fm = 64'h3333_0000_0000_0000 + 64'(i);
         4:       fm = 64'h4444_0000_0000_0000 + 64'(i);
         default: fm = 64'h5555_AAAA_5555_AAAA;
      endcase
   endfunction

   function automatic logic [63:0] pt(input int frame, input int i);
      logic [63:0] v;
      v = 64'(i);
      if (frame == 1) pt = ~v;
      else            pt = fm(frame, i) ^ 64'h0F0F_F0F0_1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_word(input logic [63:0] f, input logic [63:0] p);
      bus.i_data_valid = 1'b1;
      bus.i_fmap       = f;
      bus.i_patchdata  = p;
      @(negedge s_clk);
      bus.i_data_valid = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [11:0] addr,
                          input logic [63:0] ef, input logic [63:0] ep);
      bus.i_rd_req  = 1'b1;
      bus.i_rd_addr = addr;
      @(negedge s_clk);
      bus.i_rd_req  = 1'b0;
      chk({tag, "_valid"}, bus.o_rd_valid, 1'b1);
      chk({tag, "_fmap"},  bus.o_rd_fmap,  ef);
      chk({tag, "_patch"}, bus.o_rd_patch, ep);
      @(negedge s_clk);
      chk({tag, "_pulse"}, bus.o_rd_valid, 1'b0);
      chk({tag, "_hold"},  bus.o_rd_fmap,  ef);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      s_rst_n          = 1'b0;
      bus.i_data_valid = 1'b0;
      bus.i_fmap       = '0;
      bus.i_patchdata  = '0;
      bus.i_attn_done  = 1'b0;
      bus.i_rd_req     = 1'b0;
      bus.i_rd_addr    = '0;
      repeat (2) @(negedge s_clk);
      s_rst_n = 1'b1;
      @(negedge s_clk);

      chk("rst_ready", bus.o_frame_ready, 1'b0);
      chk("rst_cnt",   bus.o_wr_cnt,      13'd0);
      chk("rst_ovf",   bus.o_overflow,    1'b0);
      chk("rst_rdv",   bus.o_rd_valid,    1'b0);
      chk("rst_fmap",  bus.o_rd_fmap,     64'd0);
      chk("rst_patch", bus.o_rd_patch,    64'd0);

      // full-rate frame 1; a read in FILL must be ignored
      bus.i_rd_req = 1'b1;
      for (int i = 0; i < 3072; i++) begin
         if (i == 3071) chk("f1_not_ready_before_last", bus.o_frame_ready, 1'b0);
         drive_word(fm(1, i), pt(1, i));
         bus.i_rd_req = 1'b0;
         if (i == 0) chk("fill_read_ignored", bus.o_rd_valid, 1'b0);
      end
      chk("f1_ready", bus.o_frame_ready, 1'b1);
      chk("f1_cnt",   bus.o_wr_cnt,      13'd3072);
      do_read("f1_rd3071", 12'd3071, fm(1, 3071), pt(1, 3071));
      do_read("f1_rd0",    12'd0,    fm(1, 0),    pt(1, 0));
      do_read("f1_rd1535", 12'd1535, fm(1, 1535), pt(1, 1535));

      // back-to-back reads
      bus.i_rd_req = 1'b1; bus.i_rd_addr = 12'd7;
      @(negedge s_clk);
      bus.i_rd_addr = 12'd2048;
      chk("b2b_a_valid", bus.o_rd_valid, 1'b1);
      chk("b2b_a_fmap",  bus.o_rd_fmap,  fm(1, 7));
      @(negedge s_clk);
      bus.i_rd_req = 1'b0;
      chk("b2b_b_valid", bus.o_rd_valid, 1'b1);
      chk("b2b_b_patch", bus.o_rd_patch, pt(1, 2048));
      @(negedge s_clk);

      // overflow
      for (int i = 0; i < 5; i++) drive_word(64'hBAD0 + 64'(i), 64'hBAD1);
      chk("ovf_set",   bus.o_overflow,    1'b1);
      chk("ovf_cnt",   bus.o_wr_cnt,      13'd3072);
      chk("ovf_ready", bus.o_frame_ready, 1'b1);
      do_read("ovf_rd0", 12'd0, fm(1, 0), pt(1, 0));

      // out-of-range read
      do_read("oor_4000", 12'd4000, 64'd0, 64'd0);
      do_read("oor_3072", 12'd3072, 64'd0, 64'd0);

      // release with a coincident read
      bus.i_attn_done = 1'b1;
      bus.i_rd_req = 1'b1; bus.i_rd_addr = 12'd5;
      @(negedge s_clk);
      bus.i_attn_done = 1'b0; bus.i_rd_req = 1'b0;
      chk("rel_ready", bus.o_frame_ready, 1'b0);
      chk("rel_cnt",   bus.o_wr_cnt,      13'd0);
      chk("rel_rdv",   bus.o_rd_valid,    1'b1);
      chk("rel_fmap",  bus.o_rd_fmap,     fm(1, 5));
      chk("rel_ovf",   bus.o_overflow,    1'b1);

      // gapped frame 2
      for (int i = 0; i < 3072; i++) begin
         if (i == 3071) begin
            chk("f2_not_ready_before_last", bus.o_frame_ready, 1'b0);
            chk("f2_cnt_before_last",       bus.o_wr_cnt,      13'd3071);
         end
         drive_word(fm(2, i), pt(2, i));
         if (i == 3071) chk("f2_ready_after_last", bus.o_frame_ready, 1'b1);
         else repeat ($urandom_range(0, 3)) @(negedge s_clk);
      end
      chk("f2_cnt", bus.o_wr_cnt,   13'd3072);
      chk("f2_ovf", bus.o_overflow, 1'b1);
      do_read("f2_rd0",    12'd0,    fm(2, 0),    pt(2, 0));
      do_read("f2_rd1535", 12'd1535, fm(2, 1535), pt(2, 1535));
      do_read("f2_rd3071", 12'd3071, fm(2, 3071), pt(2, 3071));

      // release, partial fill to 100, abort with coincident word
      bus.i_attn_done = 1'b1;
      @(negedge s_clk);
      bus.i_attn_done = 1'b0;
      for (int i = 0; i < 100; i++) drive_word(fm(3, i), pt(3, i));
      chk("ab_cnt100", bus.o_wr_cnt, 13'd100);
      bus.i_attn_done = 1'b1;
      drive_word(fm(5, 0), pt(5, 0));
      bus.i_attn_done = 1'b0;
      chk("ab_cnt1",  bus.o_wr_cnt,      13'd1);
      chk("ab_ready", bus.o_frame_ready, 1'b0);
      for (int i = 1; i < 3072; i++) drive_word(fm(3, i), pt(3, i));
      chk("ab_full_ready", bus.o_frame_ready, 1'b1);
      do_read("ab_rd0",    12'd0,    fm(5, 0),    pt(5, 0));
      do_read("ab_rd1",    12'd1,    fm(3, 1),    pt(3, 1));
      do_read("ab_rd3071", 12'd3071, fm(3, 3071), pt(3, 3071));

      // release, fill to 2000, asynchronous reset mid-fill
      bus.i_attn_done = 1'b1;
      @(negedge s_clk);
      bus.i_attn_done = 1'b0;
      for (int i = 0; i < 2000; i++) drive_word(fm(4, i), pt(4, i));
      chk("mr_cnt2000", bus.o_wr_cnt, 13'd2000);
      #2;
      s_rst_n = 1'b0;
      #1;
      chk("ar_cnt",   bus.o_wr_cnt,      13'd0);
      chk("ar_ovf",   bus.o_overflow,    1'b0);
      chk("ar_ready", bus.o_frame_ready, 1'b0);
      chk("ar_rdv",   bus.o_rd_valid,    1'b0);
      chk("ar_fmap",  bus.o_rd_fmap,     64'd0);
      chk("ar_patch", bus.o_rd_patch,    64'd0);
      @(negedge s_clk);
      s_rst_n = 1'b1;
      @(negedge s_clk);
      for (int i = 0; i < 3072; i++) drive_word(fm(4, i) + 64'h1_0000, pt(4, i));
      chk("pr_ready", bus.o_frame_ready, 1'b1);
      chk("pr_cnt",   bus.o_wr_cnt,      13'd3072);
      chk("pr_ovf",   bus.o_overflow,    1'b0);
      do_read("pr_rd2500", 12'd2500, fm(4, 2500) + 64'h1_0000, pt(4, 2500));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sps_stream_receiver.md
# sps_stream_receiver

Receiving end of the SPS-to-attention stream. The SPS output stage broadcasts one fmap word and one patch word per cycle under a single valid strobe, with no backpressure, for 3072 consecutive words (384 channels × 8 rows). This block captures that frame into a local dual-port buffer and, once the frame is complete, serves random-access reads to the attention part. The attention part releases the buffer when it is done so the next frame can be captured.

## Interface
Parameters:
- `DATA_W`, default 64: width of each fmap word and each patch word.
- `DEPTH`, default 3072: words per frame (384 × 8).
- `ADDR_W`, default 12: read/write address width; must satisfy 2^ADDR_W ≥ DEPTH.

Ports (name, direction, width, meaning):
- `s_clk`, in, 1: the single clock.
- `s_rst_n`, in, 1: reset, asynchronous and active-low.
- `i_data_valid`, in, 1: a stream word is present this cycle.
- `i_fmap`, in, DATA_W: fmap word.
- `i_patchdata`, in, DATA_W: patch word.
- `i_attn_done`, in, 1: single-cycle pulse; releases the buffer or aborts a partial fill.
- `i_rd_req`, in, 1: read request.
- `i_rd_addr`, in, ADDR_W: read word address.
- `o_rd_valid`, out, 1: read data valid.
- `o_rd_fmap`, out, DATA_W: read fmap word.
- `o_rd_patch`, out, DATA_W: read patch word.
- `o_frame_ready`, out, 1: a complete frame is held in the buffer.
- `o_wr_cnt`, out, ADDR_W+1: number of words captured so far in the current frame.
- `o_overflow`, out, 1: sticky flag; a stream word was dropped.

## Operation
- There are two states, FILL and READY. Reset enters FILL.
- **FILL**:
  - On `i_data_valid`, write {`i_fmap`, `i_patchdata`} at address `o_wr_cnt`, then increment `o_wr_cnt`.
  - The write of word DEPTH-1 moves the block to READY. `o_wr_cnt` then holds DEPTH.
  - `i_rd_req` is ignored and `o_rd_valid` stays 0.
  - `i_attn_done` aborts the partial frame: `o_wr_cnt` goes to 0 and the block stays in FILL. If a valid word arrives in the same cycle, it is written at address 0 and `o_wr_cnt` becomes 1.
- **READY**:
  - `o_frame_ready` = 1.
  - Each `i_rd_req` returns the stored pair at `i_rd_addr`.
  - If `i_rd_addr` ≥ DEPTH, the read still returns `o_rd_valid` = 1, with both data outputs forced to 0.
  - Any `i_data_valid` in READY is dropped and sets `o_overflow`.
  - `i_attn_done` moves the block to FILL and sets `o_wr_cnt` to 0. A `i_data_valid` in that same cycle is dropped and sets `o_overflow`.
- `o_overflow` is cleared only by reset.
- Buffer contents are never cleared, including on reset. Only the count and state gate their use.

## Timing
- Reset values:
  - `o_rd_valid` = 0, `o_rd_fmap` = 0, `o_rd_patch` = 0.
  - `o_frame_ready` = 0, `o_wr_cnt` = 0, `o_overflow` = 0.
  - State = FILL.
- Write latency:
  - A word valid at cycle N is readable from cycle N+1.
  - The last word at cycle N gives `o_frame_ready` = 1 at N+1. A read request at N+1 is honoured.
- Read latency:
  - `i_rd_req` at cycle N gives `o_rd_valid` = 1 and data at N+1.
  - `o_rd_valid` is a 1-cycle pulse per request. Back-to-back requests give one result per cycle.
  - Data outputs hold their last value between reads.
- `i_attn_done` at cycle N gives `o_frame_ready` = 0 and `o_wr_cnt` = 0 at N+1. A read requested at N still completes at N+1.
- The stream has no backpressure. Full-rate `i_data_valid` (every cycle) must be sustained in FILL.
- Counter behaviour:
  - `o_wr_cnt` saturates at DEPTH and never wraps.
  - The write address is the lower ADDR_W bits of the count.

## Structure
- Shared package `sps_rx_pkg` holds:
  - the `DEPTH` and `ADDR_W` defaults;
  - the state enum (FILL, READY).
- Sub-module `sps_rx_dpram`: simple dual-port RAM.
  - 2·DATA_W wide × DEPTH deep, storing the fmap in the upper half and the patch in the lower half.
  - Synchronous write port and registered read port (1-cycle latency).
  - Inferable as block RAM.
- The top level holds the FSM, the counter, the overflow flag, the out-of-range zeroing and the output registers.

## Test plan
- **Full frame:** 3072 consecutive valid words, with fmap = index and patch = ~index -> `o_frame_ready` rises one cycle after the last word and `o_wr_cnt` = 3072. Reading addresses 0, 1535 and 3071 returns the matching pairs one cycle after each request.
- **Gapped stream:** words with random 0–3 idle cycles between them -> same contents. `o_frame_ready` rises exactly after word 3071 is written.
- **Overflow:** 5 extra valid words after the frame completes -> `o_overflow` = 1, and reading address 0 still returns word 0.
- **Release and refill:** `i_attn_done` pulse, then a second frame with different data -> `o_frame_ready` falls the next cycle, then rises again. Reads return the new data and `o_overflow` stays at its prior value.
- **Abort and edge reads:**
  - `i_attn_done` during FILL at `o_wr_cnt` = 100, coincident with a valid word -> `o_wr_cnt` = 1 and that word is stored at address 0.
  - A read with `i_rd_addr` = 4000 in READY -> `o_rd_valid` = 1 with zero data.
- **Reset mid-fill:** deassert `s_rst_n` at `o_wr_cnt` = 2000 -> all outputs return to their reset values immediately (asynchronously). The next 3072-word frame completes normally.
